// File: rtl/alu_cop_param_if.sv
// -----------------------------------------------------------------------------
// alu_cop_param_if
//   Bundles the host issue handshake, the shared register-bus signals and the
//   result/status outputs of the ALU coprocessor.
//
//   master : host sequencer + bus slave side (drives op/imm and bus_rdy/rd_data)
//   slave  : the coprocessor itself
//
//   op_valid/op_ready/opcode/imm  issue handshake
//   bus_req/bus_rdy               bus phase request (00 idle, 01 read, 10 write)
//   bus_rd_data/bus_wr_data/bus_oe operand in, result out, output-enable
//   res_valid/result/carry/zero/err completion pulse and status
// -----------------------------------------------------------------------------
interface alu_cop_param_if #(
    parameter int DW = 8
);
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    opcode;
    logic [DW-1:0] imm;
    logic [1:0]    bus_req;
    logic          bus_rdy;
    logic [DW-1:0] bus_rd_data;
    logic [DW-1:0] bus_wr_data;
    logic          bus_oe;
    logic          res_valid;
    logic [DW-1:0] result;
    logic          carry;
    logic          zero;
    logic          err;

    modport master (
        output op_valid, opcode, imm, bus_rdy, bus_rd_data,
        input  op_ready, bus_req, bus_wr_data, bus_oe,
               res_valid, result, carry, zero, err
    );

    modport slave (
        input  op_valid, opcode, imm, bus_rdy, bus_rd_data,
        output op_ready, bus_req, bus_wr_data, bus_oe,
               res_valid, result, carry, zero, err
    );
endinterface

// File: rtl/alu_cop_param.sv
// -----------------------------------------------------------------------------
// alu_cop_param
//   DW-bit ALU coprocessor. Accepts opcode+immediate from the host, fetches
//   one (immediate ops) or two (register ops) operands over the shared bus,
//   computes, writes the result back over the bus and pulses res_valid.
//   Each bus phase is guarded by a timeout (BUS_TIMEOUT cycles, 0 = none).
//
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   cop   : alu_cop_param_if.slave (handshake, bus, result/status)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | op_ready=1, waiting for op_valid
//   FETCH_A | bus read of first operand (register ops only)
//   FETCH_B | bus read of last operand
//   EXEC    | compute {carry,result} into the write-back register
//   WRITE   | bus write of the computed result, bus_oe=1
//   DONE    | res_valid pulse, err reports illegal opcode or bus timeout
// -----------------------------------------------------------------------------
module alu_cop_param #(
    parameter int DW          = 8,
    parameter int BUS_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    alu_cop_param_if.slave  cop
);

    localparam logic [1:0] REQ_IDLE = 2'b00;
    localparam logic [1:0] REQ_RD   = 2'b01;
    localparam logic [1:0] REQ_WR   = 2'b10;

    localparam int              TW       = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [TW:0]     TO_LIMIT = (TW + 1)'(BUS_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [3:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] wr_q;
    logic          wr_carry_q;
    logic          err_q;
    logic [TW-1:0] tcnt_q;
    logic [DW-1:0] result_q;
    logic          carry_q;
    logic          zero_q;

    logic          op_ready;
    logic [1:0]    bus_req;
    logic          bus_oe;
    logic          res_valid;
    logic          bus_wait;
    logic          to_hit;
    logic [TW:0]   tcnt_inc;

    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW:0]   shr_ext;
    logic [DW:0]   shl_ext;
    logic          shift_big;

    function automatic logic op_is_imm(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd3) || (op == 4'd6) || (op == 4'd7);
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction

    // Timeout fires on the wait cycle that brings the count to BUS_TIMEOUT.
    assign tcnt_inc = (TW + 1)'(tcnt_q) + (TW + 1)'(1);
    assign to_hit   = (BUS_TIMEOUT != 0) && (tcnt_inc == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        bus_req    = REQ_IDLE;
        bus_oe     = 1'b0;
        res_valid  = 1'b0;
        bus_wait   = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (cop.op_valid) begin
                    if (!op_is_legal(cop.opcode)) begin
                        state_next = S_DONE;
                    end else if (op_is_imm(cop.opcode)) begin
                        state_next = S_FETCH_B;
                    end else begin
                        state_next = S_FETCH_A;
                    end
                end
            end
            S_FETCH_A: begin
                bus_req  = REQ_RD;
                bus_wait = !cop.bus_rdy;
                if (cop.bus_rdy) begin
                    state_next = S_FETCH_B;
                end else if (to_hit) begin
                    state_next = S_DONE;
                end
            end
            S_FETCH_B: begin
                bus_req  = REQ_RD;
                bus_wait = !cop.bus_rdy;
                if (cop.bus_rdy) begin
                    state_next = S_EXEC;
                end else if (to_hit) begin
                    state_next = S_DONE;
                end
            end
            S_EXEC: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                bus_req  = REQ_WR;
                bus_oe   = 1'b1;
                bus_wait = !cop.bus_rdy;
                if (cop.bus_rdy || to_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Shifts use an extra bit so the last bit shifted out lands in bit 0
    // (right) or bit DW (left); shift by 0 naturally yields carry 0.
    assign sum       = {1'b0, a_q} + {1'b0, b_q};
    assign diff      = {1'b0, b_q} - {1'b0, a_q};
    assign shr_ext   = {b_q, 1'b0} >> a_q;
    assign shl_ext   = {1'b0, b_q} << a_q;
    assign shift_big = (32'(a_q) >= DW);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            4'd1, 4'd2: {alu_carry, alu_res} = sum;
            4'd3, 4'd4: {alu_carry, alu_res} = diff;
            4'd5:       alu_res = ~(a_q & b_q);
            4'd6: begin
                if (!shift_big) begin
                    alu_res   = shr_ext[DW:1];
                    alu_carry = shr_ext[0];
                end
            end
            4'd7: begin
                if (!shift_big) begin
                    alu_res   = shl_ext[DW-1:0];
                    alu_carry = shl_ext[DW];
                end
            end
            4'd8:       alu_res = a_q & b_q;
            4'd9:       alu_res = a_q | b_q;
            4'd10:      alu_res = a_q ^ b_q;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wr_q       <= '0;
            wr_carry_q <= 1'b0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cop.op_valid) begin
                        op_q  <= cop.opcode;
                        a_q   <= cop.imm;
                        err_q <= !op_is_legal(cop.opcode);
                    end
                end
                S_FETCH_A: begin
                    if (cop.bus_rdy) begin
                        a_q <= cop.bus_rd_data;
                    end
                end
                S_FETCH_B: begin
                    if (cop.bus_rdy) begin
                        b_q <= cop.bus_rd_data;
                    end
                end
                S_EXEC: begin
                    wr_q       <= alu_res;
                    wr_carry_q <= alu_carry;
                end
                S_WRITE: begin
                    if (cop.bus_rdy) begin
                        result_q <= wr_q;
                        carry_q  <= wr_carry_q;
                        zero_q   <= (wr_q == '0);
                    end
                end
                default: begin
                end
            endcase
            if (bus_wait && to_hit) begin
                err_q <= 1'b1;
            end
            // Any cycle that is not a bus wait clears the count, so every
            // bus phase starts from zero.
            if (bus_wait) begin
                tcnt_q <= tcnt_q + 1'b1;
            end else begin
                tcnt_q <= '0;
            end
        end
    end

    assign cop.op_ready    = op_ready;
    assign cop.bus_req     = bus_req;
    assign cop.bus_oe      = bus_oe;
    assign cop.bus_wr_data = (state == S_WRITE) ? wr_q : '0;
    assign cop.res_valid   = res_valid;
    assign cop.err         = res_valid & err_q;
    assign cop.result      = result_q;
    assign cop.carry       = carry_q;
    assign cop.zero        = zero_q;

endmodule
